monocicle_run_ctrl: RTL and testbench
=====================================

Name: monocicle_run_ctrl

Overview:
Run/step/halt sequencer for the single-cycle RISC-V core (monocicle). It drives one clock enable, core_ce, that gates every architectural state update: PC, register file write (ruwr) and data-memory write (dmwr). Stop conditions are user halt, PC breakpoint and EBREAK. It also counts retired instructions for board-level debug and display.

Parameters:
XLEN, 32, width of pc, instr and bp_addr
CNT_W, 32, width of retired-instruction counter
EBREAK_ENC, 32'h00100073, instruction encoding treated as a halt trap

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
run_req  in  1  single-cycle pulse: free-run from HALT
step_req  in  1  single-cycle pulse: execute exactly one instruction from HALT
halt_req  in  1  single-cycle pulse: stop RUN
bp_en  in  1  breakpoint enable
bp_addr  in  XLEN  breakpoint PC
cnt_clr  in  1  synchronous clear of retired counter
pc  in  XLEN  core pc_out (current instruction address)
instr  in  XLEN  core ins_memory_out (current instruction)
core_ce  out  1  core state-update enable (combinational, see below)
halted  out  1  1 when state==HALT
state  out  2  0=HALT, 1=RUN, 2=STEP
halt_cause  out  2  0=reset, 1=user halt, 2=breakpoint, 3=EBREAK
retired  out  CNT_W  count of cycles with core_ce=1

Behaviour:
- Reset (rst_n=0, async): state=HALT, halted=1, halt_cause=0, retired=0, resume_skip=0, core_ce=0. Deassertion takes effect at the next clk edge.
- stop_now is combinational: halt_req | is_ebreak | bp_hit.
  - is_ebreak = (instr==EBREAK_ENC).
  - bp_hit = bp_en & (pc==bp_addr) & ~resume_skip.
- core_ce is combinational:
  - RUN: core_ce = ~stop_now.
  - STEP: core_ce = ~is_ebreak.
  - HALT: core_ce = 0.
  - The stopping instruction is therefore never executed; a breakpoint or EBREAK halts with the PC still pointing at it.
- HALT transitions:
  - step_req -> STEP (step_req wins if run_req is also asserted).
  - else run_req -> RUN.
  - Either transition sets resume_skip=1.
  - halt_req is ignored in HALT.
- RUN transitions (causes checked in this order):
  - halt_req -> HALT, cause 1.
  - else is_ebreak -> HALT, cause 3.
  - else bp_hit -> HALT, cause 2.
  - else stay in RUN.
  - run_req and step_req are ignored in RUN.
- STEP: always -> HALT after one cycle.
  - Cause 3 if is_ebreak, otherwise cause 1.
  - halt_req during STEP has no additional effect.
- resume_skip: cleared on any cycle with core_ce=1. It lets RUN or STEP leave a breakpoint address without re-triggering, and is held while in HALT.
- EBREAK is not skippable. Resuming on EBREAK halts again with zero instructions retired; software or the loader must move the PC.
- retired:
  - Increments by 1 on each edge where core_ce=1.
  - Saturates at all-ones (no wrap).
  - cnt_clr has priority over increment; it clears to 0 that edge.
  - Clearing is allowed in any state.
- halt_cause holds its value until the next entry into HALT and is unchanged while running.
- Reset asserted mid-RUN or mid-STEP: immediate HALT and core_ce=0 without waiting for clk. The core sees no enabled edge.
- All inputs are synchronous to clk. Button debounce and sync are the board wrapper's job.

Test Plan:
- Reset then idle 5 cycles -> state=0, halted=1, core_ce=0, retired=0, halt_cause=0.
- step_req pulse at pc=0x0, instr=0x00500093 -> exactly one cycle core_ce=1, state back to 0, retired=1, halt_cause=1. A second step_req gives retired=2.
- bp_en=1, bp_addr=0x10, run_req, pc advancing by 4 per enabled cycle -> core_ce=1 for pc=0x0,0x4,0x8,0xC, then 0 at pc=0x10. State=0, halt_cause=2, retired=4. A following run_req executes 0x10 (core_ce=1) and continues.
- RUN with instr=0x00100073 at pc=0x8 -> core_ce=0 that cycle, halt_cause=3, retired=2. A subsequent step_req keeps retired=2 and halt_cause=3.
- RUN with halt_req and bp_hit in the same cycle -> halt_cause=1, core_ce=0. Simultaneous run_req+step_req in HALT -> STEP (one retire only).
- Preset retired=0xFFFFFFFE, run 3 cycles -> retired=0xFFFFFFFF (saturated). cnt_clr together with core_ce=1 -> retired=0. rst_n low mid-RUN -> core_ce=0 asynchronously.

Source files
------------

// File: rtl/monocicle_run_ctrl.sv
// -----------------------------------------------------------------------------
// monocicle_run_ctrl
//
// Run/step/halt sequencer for the single-cycle RISC-V core. Produces one clock
// enable, core_ce, that gates every architectural update of the core (PC,
// register-file write, data-memory write). The core stops on a user halt, a
// PC breakpoint or an EBREAK instruction, and a saturating counter tracks the
// number of retired instructions for board-level debug.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   run_req     1-cycle pulse: free-run from HALT
//   step_req    1-cycle pulse: execute exactly one instruction from HALT
//   halt_req    1-cycle pulse: stop RUN
//   bp_en       breakpoint enable
//   bp_addr     breakpoint PC
//   cnt_clr     synchronous clear of the retired counter
//   pc          core current instruction address
//   instr       core current instruction word
//   core_ce     core state-update enable (combinational)
//   halted      1 while in HALT
//   state       0=HALT, 1=RUN, 2=STEP
//   halt_cause  0=reset, 1=user halt, 2=breakpoint, 3=EBREAK
//   retired     count of edges with core_ce=1, saturating
// -----------------------------------------------------------------------------
module monocicle_run_ctrl #(
  parameter int unsigned          XLEN       = 32,
  parameter int unsigned          CNT_W      = 32,
  parameter logic [XLEN-1:0]      EBREAK_ENC = 'h00100073
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             bp_en,
  input  logic [XLEN-1:0]  bp_addr,
  input  logic             cnt_clr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  instr,
  output logic             core_ce,
  output logic             halted,
  output logic [1:0]       state,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_RESET  = 2'd0,
    CAUSE_USER   = 2'd1,
    CAUSE_BP     = 2'd2,
    CAUSE_EBREAK = 2'd3
  } cause_t;

  state_t           state_q;
  cause_t           cause_q;
  logic             resume_skip_q;
  logic [CNT_W-1:0] retired_q;

  logic is_ebreak;
  logic bp_hit;
  logic stop_now;

  // Stop detection looks at the instruction currently presented by the core,
  // so the stopping instruction is never executed and the PC stays on it.
  // resume_skip masks the breakpoint for the first instruction after a resume
  // so the core can leave the breakpoint address; EBREAK is never masked.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    is_ebreak = 1'b0;
    bp_hit    = 1'b0;
    stop_now  = 1'b0;
    core_ce   = 1'b0;

    is_ebreak = (instr == EBREAK_ENC);
    bp_hit    = bp_en && (pc == bp_addr) && !resume_skip_q;
    stop_now  = halt_req || is_ebreak || bp_hit;

    case (state_q)
      ST_RUN:  core_ce = !stop_now;
      ST_STEP: core_ce = !is_ebreak;
      default: core_ce = 1'b0;
    endcase
  end

  // Reset forces HALT asynchronously, which drops core_ce immediately through
  // the decode above: the core never sees an enabled edge during reset.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_HALT;
      cause_q       <= CAUSE_RESET;
      resume_skip_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      if (core_ce) begin
        resume_skip_q <= 1'b0;
      end

      case (state_q)
        ST_HALT: begin
          // step_req wins over run_req; halt_req is meaningless here.
          if (step_req) begin
            state_q       <= ST_STEP;
            resume_skip_q <= 1'b1;
          end else if (run_req) begin
            state_q       <= ST_RUN;
            resume_skip_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            state_q <= ST_HALT;
            cause_q <= CAUSE_USER;
          end else if (is_ebreak) begin
            state_q <= ST_HALT;
            cause_q <= CAUSE_EBREAK;
          end else if (bp_hit) begin
            state_q <= ST_HALT;
            cause_q <= CAUSE_BP;
          end
        end
        ST_STEP: begin
          state_q <= ST_HALT;
          cause_q <= is_ebreak ? CAUSE_EBREAK : CAUSE_USER;
        end
        default: begin
          state_q <= ST_HALT;
        end
      endcase

      // Clear beats increment; the counter sticks at all-ones instead of
      // wrapping so a long free-run never reads back as a small number.
      if (cnt_clr) begin
        retired_q <= '0;
      end else if (core_ce && (retired_q != '1)) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  assign halted     = (state_q == ST_HALT);
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_monocicle_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_monocicle_run_ctrl
//
// Directed-vector bench with a scoreboard. Each stimulus vector carries the
// hand-computed response expected in the same cycle; the driver pushes it into
// a queue and a separate monitor pops and compares at the falling edge.
// A second instance with a 3-bit counter exercises saturation; its expected
// value is the main counter clamped at 7.
// -----------------------------------------------------------------------------
module tb_monocicle_run_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] EBK  = 32'h0010_0073;
  localparam logic [1:0]  H = 2'd0, R = 2'd1, S = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        run_req, step_req, halt_req, bp_en, cnt_clr;
  logic [31:0] bp_addr, pc, instr;

  logic        core_ce, halted;
  logic [1:0]  state, halt_cause;
  logic [31:0] retired;

  logic        sat_ce, sat_halted;
  logic [1:0]  sat_state, sat_cause;
  logic [2:0]  sat_retired;

  monocicle_run_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .cnt_clr    (cnt_clr),
    .pc         (pc),
    .instr      (instr),
    .core_ce    (core_ce),
    .halted     (halted),
    .state      (state),
    .halt_cause (halt_cause),
    .retired    (retired)
  );

  monocicle_run_ctrl #(.CNT_W(3)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .run_req    (run_req),
    .step_req   (step_req),
    .halt_req   (halt_req),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .cnt_clr    (cnt_clr),
    .pc         (pc),
    .instr      (instr),
    .core_ce    (sat_ce),
    .halted     (sat_halted),
    .state      (sat_state),
    .halt_cause (sat_cause),
    .retired    (sat_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        rst_n, run, step, hlt, clr;
    logic [31:0] pc, instr;
    logic        ce;
    logic [1:0]  st, cause;
    logic [31:0] ret;
  } vec_t;

  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   next_id  = 0;

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  function automatic vec_t v(input logic rst_i, run_i, step_i, hlt_i, clr_i,
                             input logic [31:0] pc_i, instr_i,
                             input logic ce_i, input logic [1:0] st_i, cause_i,
                             input logic [31:0] ret_i);
    vec_t e;
    e.id = 0;
    e.rst_n = rst_i; e.run = run_i; e.step = step_i; e.hlt = hlt_i; e.clr = clr_i;
    e.pc = pc_i; e.instr = instr_i;
    e.ce = ce_i; e.st = st_i; e.cause = cause_i; e.ret = ret_i;
    return e;
  endfunction

  // Inputs change just after the rising edge. A vector that asserts reset
  // drops rst_n a little later in the cycle, with no clock edge before the
  // monitor samples, so the check sees the asynchronous effect.
  task automatic drive(input vec_t e);
    @(posedge clk);
    #1;
    run_req  = e.run;
    step_req = e.step;
    halt_req = e.hlt;
    cnt_clr  = e.clr;
    pc       = e.pc;
    instr    = e.instr;
    if (!e.rst_n) #2;
    rst_n    = e.rst_n;
    e.id     = next_id;
    next_id++;
    exp_q.push_back(e);
  endtask

  // Monitor: compares whatever the DUT presents against the next expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      logic [31:0] exp_sat;
      e = exp_q.pop_front();
      exp_sat = (e.ret > 32'd7) ? 32'd7 : e.ret;
      check("core_ce",     e.id, {31'd0, core_ce},     {31'd0, e.ce});
      check("state",       e.id, {30'd0, state},       {30'd0, e.st});
      check("halted",      e.id, {31'd0, halted},      {31'd0, (e.st == H)});
      check("halt_cause",  e.id, {30'd0, halt_cause},  {30'd0, e.cause});
      check("retired",     e.id, retired,              e.ret);
      check("sat_retired", e.id, {29'd0, sat_retired}, exp_sat);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    run_req = 1'b0; step_req = 1'b0; halt_req = 1'b0; cnt_clr = 1'b0;
    bp_en = 1'b1; bp_addr = 32'h10;
    pc = 32'h0; instr = NOP;

    //      rst run stp hlt clr  pc      instr  ce st cause ret
    // Reset held, then released and idle for five cycles.
    drive(v(0, 0, 0, 0, 0, 32'h00, NOP,  0, H, 0, 0));
    drive(v(0, 0, 0, 0, 0, 32'h00, NOP,  0, H, 0, 0));
    for (int i = 0; i < 5; i++)
      drive(v(1, 0, 0, 0, 0, 32'h00, NOP,  0, H, 0, 0));

    // Single steps: one enabled cycle each.
    drive(v(1, 0, 1, 0, 0, 32'h00, ADDI, 0, H, 0, 0));
    drive(v(1, 0, 0, 0, 0, 32'h00, ADDI, 1, S, 0, 0));
    drive(v(1, 0, 0, 0, 0, 32'h04, NOP,  0, H, 1, 1));
    drive(v(1, 0, 1, 0, 0, 32'h04, NOP,  0, H, 1, 1));
    drive(v(1, 0, 0, 0, 0, 32'h04, NOP,  1, S, 1, 1));
    drive(v(1, 0, 0, 0, 0, 32'h08, NOP,  0, H, 1, 2));

    // Clear counter, run to breakpoint at 0x10.
    drive(v(1, 1, 0, 0, 1, 32'h00, NOP,  0, H, 1, 2));
    drive(v(1, 0, 0, 0, 0, 32'h00, NOP,  1, R, 1, 0));
    drive(v(1, 0, 0, 0, 0, 32'h04, NOP,  1, R, 1, 1));
    drive(v(1, 0, 0, 0, 0, 32'h08, NOP,  1, R, 1, 2));
    drive(v(1, 0, 0, 0, 0, 32'h0C, NOP,  1, R, 1, 3));
    drive(v(1, 0, 0, 0, 0, 32'h10, NOP,  0, R, 1, 4));
    drive(v(1, 0, 0, 0, 0, 32'h10, NOP,  0, H, 2, 4));

    // Resume from the breakpoint: 0x10 executes, step_req ignored in RUN,
    // then EBREAK at 0x18 halts without executing.
    drive(v(1, 1, 0, 0, 0, 32'h10, NOP,  0, H, 2, 4));
    drive(v(1, 0, 0, 0, 0, 32'h10, NOP,  1, R, 2, 4));
    drive(v(1, 0, 1, 0, 0, 32'h14, NOP,  1, R, 2, 5));
    drive(v(1, 0, 0, 0, 0, 32'h18, EBK,  0, R, 2, 6));
    drive(v(1, 0, 0, 0, 0, 32'h18, EBK,  0, H, 3, 6));

    // Step and run on EBREAK: nothing retires, cause stays EBREAK.
    drive(v(1, 0, 1, 0, 0, 32'h18, EBK,  0, H, 3, 6));
    drive(v(1, 0, 0, 0, 0, 32'h18, EBK,  0, S, 3, 6));
    drive(v(1, 0, 0, 0, 0, 32'h18, EBK,  0, H, 3, 6));
    drive(v(1, 1, 0, 0, 0, 32'h18, EBK,  0, H, 3, 6));
    drive(v(1, 0, 0, 0, 0, 32'h18, EBK,  0, R, 3, 6));
    drive(v(1, 0, 0, 0, 0, 32'h18, EBK,  0, H, 3, 6));

    // halt_req and breakpoint together: user halt wins.
    drive(v(1, 1, 0, 0, 0, 32'h00, NOP,  0, H, 3, 6));
    drive(v(1, 0, 0, 0, 0, 32'h00, NOP,  1, R, 3, 6));
    drive(v(1, 0, 0, 1, 0, 32'h10, NOP,  0, R, 3, 7));
    drive(v(1, 0, 0, 0, 0, 32'h10, NOP,  0, H, 1, 7));

    // halt_req in HALT does nothing.
    drive(v(1, 0, 0, 1, 0, 32'h10, NOP,  0, H, 1, 7));
    drive(v(1, 0, 0, 0, 0, 32'h10, NOP,  0, H, 1, 7));

    // run_req + step_req together: one step only; 3-bit counter saturates.
    drive(v(1, 1, 1, 0, 0, 32'h10, NOP,  0, H, 1, 7));
    drive(v(1, 0, 0, 0, 0, 32'h10, NOP,  1, S, 1, 7));
    drive(v(1, 0, 0, 0, 0, 32'h14, NOP,  0, H, 1, 8));
    drive(v(1, 0, 0, 0, 0, 32'h14, NOP,  0, H, 1, 8));

    // cnt_clr on an enabled cycle: clear beats increment.
    drive(v(1, 1, 0, 0, 0, 32'h14, NOP,  0, H, 1, 8));
    drive(v(1, 0, 0, 0, 1, 32'h14, NOP,  1, R, 1, 8));
    drive(v(1, 0, 0, 0, 0, 32'h18, NOP,  1, R, 1, 0));
    drive(v(1, 0, 0, 0, 0, 32'h1C, NOP,  1, R, 1, 1));

    // Reset dropped mid-RUN: HALT and core_ce=0 before any further edge.
    drive(v(0, 0, 0, 0, 0, 32'h20, NOP,  0, H, 0, 0));
    drive(v(0, 0, 0, 0, 0, 32'h00, NOP,  0, H, 0, 0));
    drive(v(1, 0, 0, 0, 0, 32'h00, NOP,  0, H, 0, 0));

    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
